// File: rtl/mat_pkg.sv
// Shared types and constants for the 4x4 matrix dot-product sequencer.
package mat_pkg;

  localparam int DATA_W = 32;
  localparam int DIM    = 4;
  localparam int VEC_W  = DIM * DATA_W;
  localparam int MAT_W  = DIM * DIM * DATA_W;
  localparam int JOBS   = DIM * DIM;
  localparam int IDX_W  = $clog2(DIM);
  localparam int NW     = $clog2(JOBS);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    OUT
  } state_e;

  // Bit offset of element [i][j] in a row-major packed matrix line.
  function automatic int elem_lsb(input int i, input int j);
    return (i * DIM + j) * DATA_W;
  endfunction

endpackage

// File: rtl/mat_col_gather.sv
// Combinational extraction of row i of A and column j of B into the
// four-lane operand vectors of the dot unit.
module mat_col_gather
  import mat_pkg::*;
(
  input  logic [MAT_W-1:0] a_i,
  input  logic [MAT_W-1:0] b_i,
  input  logic [IDX_W-1:0] row_i,
  input  logic [IDX_W-1:0] col_i,
  output logic [VEC_W-1:0] set_one_o,
  output logic [VEC_W-1:0] set_two_o
);

  always_comb begin
    set_one_o = '0;
    set_two_o = '0;
    for (int k = 0; k < DIM; k++) begin
      set_one_o[k*DATA_W +: DATA_W] = a_i[elem_lsb(int'(row_i), k) +: DATA_W];
      set_two_o[k*DATA_W +: DATA_W] = b_i[elem_lsb(k, int'(col_i)) +: DATA_W];
    end
  end

endmodule

// File: rtl/mat_dot_sequencer.sv
// Drives the external dot unit through 16 row/column jobs to form C = A*B.
// Optional WAIT watchdog and err port enabled by defining MAT_SEQ_TIMEOUT_EN.
module mat_dot_sequencer
  import mat_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MAT_W-1:0]  in_mat_a,
  input  logic [MAT_W-1:0]  in_mat_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAT_W-1:0]  out_mat_c,
  output logic              busy,
  output logic              dp_reset_n,
  output logic              dp_start,
  output logic [VEC_W-1:0]  dp_set_one,
  output logic [VEC_W-1:0]  dp_set_two,
  input  logic [DATA_W-1:0] dp_result,
  input  logic              dp_done
`ifdef MAT_SEQ_TIMEOUT_EN
 ,output logic              err
`endif
);

  state_e           state_q;
  logic [NW-1:0]    n_q;
  logic [MAT_W-1:0] a_q, b_q, c_q;
  logic             out_valid_q, busy_q, dp_start_q, dp_reset_n_q;

`ifdef MAT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic          err_q;
  logic [TW-1:0] timer_q;
  assign err = err_q;
`endif

  mat_col_gather u_gather (
    .a_i       (a_q),
    .b_i       (b_q),
    .row_i     (n_q[NW-1 -: IDX_W]),
    .col_i     (n_q[IDX_W-1:0]),
    .set_one_o (dp_set_one),
    .set_two_o (dp_set_two)
  );

  // Outputs are registered alongside the state they belong to; the dot unit's
  // clear is only pulsed in CLEAR so a sticky done never leaks into a new job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      dp_start_q   <= 1'b0;
      dp_reset_n_q <= 1'b0;
`ifdef MAT_SEQ_TIMEOUT_EN
      err_q        <= 1'b0;
      timer_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q          <= in_mat_a;
            b_q          <= in_mat_b;
            n_q          <= '0;
            busy_q       <= 1'b1;
            dp_reset_n_q <= 1'b0;
            dp_start_q   <= 1'b0;
            state_q      <= CLEAR;
          end
        end
        CLEAR: begin
          dp_reset_n_q <= 1'b1;
          dp_start_q   <= 1'b1;
          state_q      <= ISSUE;
        end
        ISSUE: begin
`ifdef MAT_SEQ_TIMEOUT_EN
          timer_q <= '0;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
          if (dp_done) begin
            c_q[elem_lsb(int'(n_q[NW-1 -: IDX_W]), int'(n_q[IDX_W-1:0])) +: DATA_W] <= dp_result;
            dp_start_q <= 1'b0;
            if (n_q == NW'(JOBS - 1)) begin
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              n_q          <= n_q + 1'b1;
              dp_reset_n_q <= 1'b0;
              state_q      <= CLEAR;
            end
          end
`ifdef MAT_SEQ_TIMEOUT_EN
          else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
            err_q        <= 1'b1;
            dp_reset_n_q <= 1'b0;
            dp_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign out_mat_c  = c_q;
  assign busy       = busy_q;
  assign dp_start   = dp_start_q;
  assign dp_reset_n = dp_reset_n_q;

endmodule

// File: tb/tb_mat_dot_sequencer.sv
// Directed bench for mat_dot_sequencer with a behavioural dot unit and a
// matrix-product scoreboard; the watchdog test runs when MAT_SEQ_TIMEOUT_EN is set.
module tb_mat_dot_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         inValid;
  logic         inReady;
  logic [511:0] inMatA;
  logic [511:0] inMatB;
  logic         outValid;
  logic         outReady;
  logic [511:0] outMatC;
  logic         busy;
  logic         dpResetN;
  logic         dpStart;
  logic [127:0] dpSetOne;
  logic [127:0] dpSetTwo;
  logic [31:0]  dpResult;
  logic         dpDone;
`ifdef MAT_SEQ_TIMEOUT_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;

  logic [511:0] sbQueue[$];
  int  outCount = 0;
  int  outValidCycles = 0;
  int  startCount = 0;
  int  lowCount = 0;
  int  cycleCount = 0;
  int  startCycle = 0;
  logic prevStart = 1'b0;
  logic prevRstN = 1'b0;

  bit   hangDot = 1'b0;
  logic dotActive;
  int   dotCnt;
  logic [31:0] dotAcc;

  always #5 clk = ~clk;

  mat_dot_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_mat_a   (inMatA),
    .in_mat_b   (inMatB),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_mat_c  (outMatC),
    .busy       (busy),
    .dp_reset_n (dpResetN),
    .dp_start   (dpStart),
    .dp_set_one (dpSetOne),
    .dp_set_two (dpSetTwo),
    .dp_result  (dpResult),
    .dp_done    (dpDone)
`ifdef MAT_SEQ_TIMEOUT_EN
   ,.err        (err)
`endif
  );

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [511:0] matMul(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] c = '0;
    logic [31:0]  acc, ea, eb;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 32'd0;
        for (int k = 0; k < 4; k++) begin
          ea  = a[(i*4+k)*32 +: 32];
          eb  = b[(k*4+j)*32 +: 32];
          acc = acc + ea * eb;
        end
        c[(i*4+j)*32 +: 32] = acc;
      end
    return c;
  endfunction

  function automatic logic [511:0] identScaled(input logic [31:0] s);
    logic [511:0] m = '0;
    for (int i = 0; i < 4; i++) m[(i*4+i)*32 +: 32] = s;
    return m;
  endfunction

  function automatic logic [511:0] fillAll(input logic [31:0] v);
    logic [511:0] m;
    for (int e = 0; e < 16; e++) m[e*32 +: 32] = v;
    return m;
  endfunction

  function automatic logic [511:0] rampB();
    logic [511:0] m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[(i*4+j)*32 +: 32] = 32'(16*i + j);
    return m;
  endfunction

  function automatic logic [511:0] randMat();
    logic [511:0] m;
    for (int e = 0; e < 16; e++) m[e*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [31:0] dotOf(input logic [127:0] x, input logic [127:0] y);
    logic [31:0] s = 32'd0;
    logic [31:0] xa, yb;
    for (int k = 0; k < 4; k++) begin
      xa = x[k*32 +: 32];
      yb = y[k*32 +: 32];
      s  = s + xa * yb;
    end
    return s;
  endfunction

  // Behavioural dot unit: random latency, sticky done cleared by dp_reset_n.
  always @(posedge clk) begin
    if (!dpResetN) begin
      dpDone    <= 1'b0;
      dotActive <= 1'b0;
      dotCnt    <= 0;
    end else if (dotActive) begin
      if (dotCnt == 0) begin
        if (!hangDot) begin
          dpDone    <= 1'b1;
          dpResult  <= dotAcc;
          dotActive <= 1'b0;
        end
      end else begin
        dotCnt <= dotCnt - 1;
      end
    end else if (dpStart && !dpDone) begin
      dotActive <= 1'b1;
      dotCnt    <= int'($urandom_range(0, 3));
      dotAcc    <= dotOf(dpSetOne, dpSetTwo);
    end
  end

  // Scoreboard and handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cycleCount++;
    if (!reset) begin
      if (inValid && inReady) sbQueue.push_back(matMul(inMatA, inMatB));
      if (outValid) outValidCycles++;
      if (outValid && outReady) begin
        checkOutput("sbPending", 512'(sbQueue.size() > 0), 512'(1));
        if (sbQueue.size() > 0) checkOutput("matC", outMatC, sbQueue.pop_front());
        outCount++;
      end
      if (dpStart && !prevStart) begin
        startCount++;
        startCycle = cycleCount;
        checkOutput("clearBeforeStart", 512'(prevRstN), 512'(0));
      end
      if (busy && !dpResetN) lowCount++;
    end
    prevStart = dpStart;
    prevRstN  = dpResetN;
  end

  task automatic applyStimulus(input logic [511:0] a, input logic [511:0] b);
    @(posedge clk); #1;
    inMatA  = a;
    inMatB  = b;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic waitForOutput(input int target);
    bit seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk); #1;
      if (outCount >= target) seen = 1'b1;
    end
    checkOutput("outTimeout", 512'(seen), 512'(1));
  endtask

  task automatic checkIdleAfterOut(input string tag);
    @(posedge clk); #1;
    checkOutput({tag, "_inReady"}, 512'(inReady), 512'(1));
    checkOutput({tag, "_outValid"}, 512'(outValid), 512'(0));
  endtask

  initial begin
    int s0, l0, o0, v0;
    logic [511:0] bpA, bpB, bpExp;
    bit seen;

    reset = 1'b1; inValid = 1'b0; outReady = 1'b1;
    inMatA = '0; inMatB = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_outValid", 512'(outValid), 512'(0));
    checkOutput("rst_busy", 512'(busy), 512'(0));
    checkOutput("rst_dpStart", 512'(dpStart), 512'(0));
    checkOutput("rst_dpResetN", 512'(dpResetN), 512'(0));
    checkOutput("rst_outMatC", outMatC, '0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_inReady", 512'(inReady), 512'(1));

    $display("[TB] identity times ramp");
    s0 = startCount; l0 = lowCount; o0 = outCount; v0 = outValidCycles;
    applyStimulus(identScaled(32'd1), rampB());
    waitForOutput(o0 + 1);
    checkIdleAfterOut("ident");
    checkOutput("ident_cEqualsB", outMatC, rampB());
    checkOutput("ident_starts", 512'(startCount - s0), 512'(16));
    checkOutput("ident_clearCycles", 512'(lowCount - l0), 512'(16));
    checkOutput("ident_validCycles", 512'(outValidCycles - v0), 512'(1));

    $display("[TB] all ones, all-F times ones, wrap");
    o0 = outCount;
    applyStimulus(fillAll(32'd1), fillAll(32'd1));
    waitForOutput(o0 + 1);
    checkIdleAfterOut("ones");
    checkOutput("ones_c4", outMatC, fillAll(32'd4));
    applyStimulus(fillAll(32'hFFFF_FFFF), fillAll(32'd1));
    waitForOutput(o0 + 2);
    checkIdleAfterOut("allF");
    checkOutput("allF_c", outMatC, fillAll(32'hFFFF_FFFC));
    applyStimulus(fillAll(32'h0001_0000), fillAll(32'h0001_0000));
    waitForOutput(o0 + 3);
    checkIdleAfterOut("wrap");
    checkOutput("wrap_c0", outMatC, '0);

    $display("[TB] output backpressure");
    bpA = randMat(); bpB = randMat(); bpExp = matMul(bpA, bpB);
    outReady = 1'b0;
    o0 = outCount;
    applyStimulus(bpA, bpB);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (outValid) seen = 1'b1;
    end
    checkOutput("bp_validTimeout", 512'(seen), 512'(1));
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      inValid = c[0];
      inMatA  = randMat();
      inMatB  = randMat();
      @(negedge clk);
      checkOutput("bp_cStable", outMatC, bpExp);
      checkOutput("bp_inReady", 512'(inReady), 512'(0));
      checkOutput("bp_outValid", 512'(outValid), 512'(1));
    end
    @(posedge clk); #1;
    inValid  = 1'b0;
    outReady = 1'b1;
    waitForOutput(o0 + 1);
    checkIdleAfterOut("bp");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_notCaptured", 512'(busy), 512'(0));
    checkOutput("bp_sbEmpty", 512'(sbQueue.size()), 512'(0));

    $display("[TB] reset during job 7");
    s0 = startCount;
    applyStimulus(randMat(), randMat());
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk); #1;
      if (startCount >= s0 + 8) seen = 1'b1;
    end
    checkOutput("midRst_reachJob7", 512'(seen), 512'(1));
    reset = 1'b1;
    #1;
    checkOutput("midRst_outValid", 512'(outValid), 512'(0));
    checkOutput("midRst_busy", 512'(busy), 512'(0));
    checkOutput("midRst_dpStart", 512'(dpStart), 512'(0));
    checkOutput("midRst_dpResetN", 512'(dpResetN), 512'(0));
    checkOutput("midRst_outMatC", outMatC, '0);
    checkOutput("midRst_inReady", 512'(inReady), 512'(1));
    sbQueue.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    o0 = outCount;
    applyStimulus(identScaled(32'd1), identScaled(32'd2));
    waitForOutput(o0 + 1);
    checkIdleAfterOut("afterRst");
    checkOutput("afterRst_c2I", outMatC, identScaled(32'd2));

`ifdef MAT_SEQ_TIMEOUT_EN
    $display("[TB] watchdog");
    hangDot = 1'b1;
    v0 = outValidCycles;
    s0 = startCount;
    applyStimulus(randMat(), randMat());
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk); #1;
      if (err) seen = 1'b1;
    end
    checkOutput("wd_errTimeout", 512'(seen), 512'(1));
    checkOutput("wd_singleStart", 512'(startCount - s0), 512'(1));
    checkOutput("wd_errDelay", 512'(cycleCount - startCycle), 512'(65));
    checkOutput("wd_noOutValid", 512'(outValidCycles - v0), 512'(0));
    checkOutput("wd_inReady", 512'(inReady), 512'(1));
    checkOutput("wd_dpResetN", 512'(dpResetN), 512'(0));
    repeat (4) @(posedge clk);
    #1;
    checkOutput("wd_errSticky", 512'(err), 512'(1));
    hangDot = 1'b0;
    sbQueue.delete();
    reset = 1'b1;
    #1;
    checkOutput("wd_errCleared", 512'(err), 512'(0));
    @(posedge clk); #1 reset = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
